instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/isa_pkg.sv | 117 +++++++++++
 rtl/instr_fifo.sv | 52 +++++
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction formats, field widths and
// format/immediate helpers used by the instruction encoder and the decoder.
package isa_pkg;

    localparam int unsigned OP_W       = 5;
    localparam int unsigned FUNC_W     = 2;
    localparam int unsigned REG_W      = 3;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned J_IMM_W    = 11;
    localparam int unsigned I2_IMM_W   = 8;
    localparam int unsigned I1_IMM_W   = 5;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_HALT  = 5'b00000;
    localparam opcode_t OP_NOP   = 5'b00001;
    localparam opcode_t OP_SIIC  = 5'b00010;
    localparam opcode_t OP_RTI   = 5'b00011;
    localparam opcode_t OP_J     = 5'b00100;
    localparam opcode_t OP_JR    = 5'b00101;
    localparam opcode_t OP_JAL   = 5'b00110;
    localparam opcode_t OP_JALR  = 5'b00111;
    localparam opcode_t OP_ADDI  = 5'b01000;
    localparam opcode_t OP_SUBI  = 5'b01001;
    localparam opcode_t OP_XORI  = 5'b01010;
    localparam opcode_t OP_ANDNI = 5'b01011;
    localparam opcode_t OP_BEQZ  = 5'b01100;
    localparam opcode_t OP_BNEZ  = 5'b01101;
    localparam opcode_t OP_BLTZ  = 5'b01110;
    localparam opcode_t OP_BGEZ  = 5'b01111;
    localparam opcode_t OP_ST    = 5'b10000;
    localparam opcode_t OP_LD    = 5'b10001;
    localparam opcode_t OP_SLBI  = 5'b10010;
    localparam opcode_t OP_STU   = 5'b10011;
    localparam opcode_t OP_ROLI  = 5'b10100;
    localparam opcode_t OP_SLLI  = 5'b10101;
    localparam opcode_t OP_RORI  = 5'b10110;
    localparam opcode_t OP_SRLI  = 5'b10111;
    localparam opcode_t OP_LBI   = 5'b11000;
    localparam opcode_t OP_BTR   = 5'b11001;
    localparam opcode_t OP_SHIFT = 5'b11010;
    localparam opcode_t OP_ARITH = 5'b11011;
    localparam opcode_t OP_SEQ   = 5'b11100;
    localparam opcode_t OP_SLT   = 5'b11101;
    localparam opcode_t OP_SLE   = 5'b11110;
    localparam opcode_t OP_SCO   = 5'b11111;

    typedef enum logic [2:0] {
        FMT_J    = 3'd0,
        FMT_I1   = 3'd1,
        FMT_I2   = 3'd2,
        FMT_R    = 3'd3,
        FMT_BARE = 3'd4,
        FMT_ILL  = 3'd5
    } fmt_e;

    typedef struct packed {
        opcode_t               op;
        logic [FUNC_W-1:0]     func;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic [REG_W-1:0]      rd;
        logic [IMM_W-1:0]      imm;
    } enc_req_t;

    // Instruction format selected by the opcode; SIIC is not encodable.
    function automatic fmt_e op_format(input opcode_t op);
        fmt_e f;
        case (op)
            OP_J, OP_JAL:                                   f = FMT_J;
            OP_JR, OP_JALR, OP_BEQZ, OP_BNEZ, OP_BLTZ,
            OP_BGEZ, OP_SLBI, OP_LBI:                       f = FMT_I2;
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI, OP_ST,
            OP_LD, OP_STU, OP_ROLI, OP_SLLI, OP_RORI,
            OP_SRLI:                                        f = FMT_I1;
            OP_BTR, OP_SHIFT, OP_ARITH, OP_SEQ, OP_SLT,
            OP_SLE, OP_SCO:                                 f = FMT_R;
            OP_HALT, OP_NOP, OP_RTI:                        f = FMT_BARE;
            default:                                        f = FMT_ILL;
        endcase
        return f;
    endfunction

    // Logical/shift immediates are unsigned; all others are two's-complement.
    function automatic logic imm_zero_ext(input opcode_t op);
        logic z;
        case (op)
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI,
            OP_SRLI, OP_SLBI: z = 1'b1;
            default:          z = 1'b0;
        endcase
        return z;
    endfunction

    function automatic logic fits_signed(input logic [IMM_W-1:0] imm, input int w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(IMM_W); i++) begin
            if (i >= w - 1 && imm[i] != imm[IMM_W-1]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic fits_unsigned(input logic [IMM_W-1:0] imm, input int w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < int'(IMM_W); i++) begin
            if (i >= w && imm[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Four-entry, 16-bit instruction queue with registered head word, valid,
// and occupancy; exposes next-cycle fullness so the parent can register ready.
module instr_fifo
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop,
    output logic [15:0] rdata,
    output logic        valid,
    output logic        full_nxt_c,
    output logic [2:0]  count
);

    logic [INSTR_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wp;
    logic [PTR_W-1:0]   rp;
    logic [PTR_W-1:0]   wp_n;
    logic [PTR_W-1:0]   rp_n;
    logic [CNT_W-1:0]   cnt_n;
    logic [INSTR_W-1:0] head_n;

    // Next head forwards the incoming word when it lands at the new read slot.
    always_comb begin
        wp_n       = wp + PTR_W'(push);
        rp_n       = rp + PTR_W'(pop);
        cnt_n      = count + CNT_W'(push) - CNT_W'(pop);
        head_n     = (push && (wp == rp_n)) ? wdata : mem[rp_n];
        full_nxt_c = (cnt_n == CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            valid <= 1'b0;
            rdata <= '0;
        end else begin
            if (push) mem[wp] <= wdata;
            wp    <= wp_n;
            rp    <= rp_n;
            count <= cnt_n;
            valid <= (cnt_n != '0);
            rdata <= head_n;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs opcode/register/immediate fields into 16-bit
// words and queues them toward fetch. Optional immediate range checking is
// enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [1:0]  in_func,
    input  logic [2:0]  in_rs,
    input  logic [2:0]  in_rt,
    input  logic [2:0]  in_rd,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    input  logic        halt_clr,
    output logic        halted,
    output logic [2:0]  count,
    output logic        err_illegal,
    output logic        err_range
);

    enc_req_t           req;
    fmt_e               fmt;
    logic [INSTR_W-1:0] word_c;
    logic               accept;
    logic               push;
    logic               pop;
    logic               halt_acc;
    logic               full_nxt;
    logic               halted_q;
    logic               halted_n;
    logic               err_ill_q;
    logic               err_ill_n;
    logic               in_ready_q;

    assign req = '{op: in_op, func: in_func, rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm};
    assign fmt = op_format(req.op);

    // Field packing per format; unused bits stay zero.
    always_comb begin
        word_c = '0;
        word_c[15:11] = req.op;
        case (fmt)
            FMT_J: begin
                word_c[10:0] = req.imm[J_IMM_W-1:0];
            end
            FMT_I2: begin
                word_c[10:8] = req.rs;
                word_c[7:0]  = req.imm[I2_IMM_W-1:0];
            end
            FMT_I1: begin
                word_c[10:8] = req.rs;
                word_c[7:5]  = req.rd;
                word_c[4:0]  = req.imm[I1_IMM_W-1:0];
            end
            FMT_R: begin
                word_c[10:8] = req.rs;
                word_c[7:5]  = (req.op == OP_BTR) ? 3'b000 : req.rt;
                word_c[4:2]  = req.rd;
                word_c[1:0]  = ((req.op == OP_BTR) || (req.op[4:2] == 3'b111)) ? 2'b00 : req.func;
            end
            default: ;
        endcase
    end

    // Illegal opcodes complete the handshake but never reach the queue.
    assign accept   = in_valid && in_ready_q;
    assign push     = accept && (fmt != FMT_ILL);
    assign pop      = out_valid && out_ready;
    assign halt_acc = accept && (req.op == OP_HALT);

    // An accepted HALT outranks a coincident clear; errors likewise set before clear.
    always_comb begin
        halted_n  = halted_q;
        err_ill_n = err_ill_q;
        if (halt_acc)      halted_n = 1'b1;
        else if (halt_clr) halted_n = 1'b0;
        if (accept && (fmt == FMT_ILL)) err_ill_n = 1'b1;
        else if (halt_clr)              err_ill_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q   <= 1'b0;
            err_ill_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            halted_q   <= halted_n;
            err_ill_q  <= err_ill_n;
            in_ready_q <= !full_nxt && !halted_n;
        end
    end

    assign halted      = halted_q;
    assign err_illegal = err_ill_q;
    assign in_ready    = in_ready_q;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic range_bad_c;
    logic err_rng_q;
    logic err_rng_n;

    // Immediate must survive truncation to its field under its extension rule.
    always_comb begin
        range_bad_c = 1'b0;
        case (fmt)
            FMT_J:  range_bad_c = !fits_signed(req.imm, int'(J_IMM_W));
            FMT_I2: range_bad_c = imm_zero_ext(req.op) ? !fits_unsigned(req.imm, int'(I2_IMM_W))
                                                       : !fits_signed(req.imm, int'(I2_IMM_W));
            FMT_I1: range_bad_c = imm_zero_ext(req.op) ? !fits_unsigned(req.imm, int'(I1_IMM_W))
                                                       : !fits_signed(req.imm, int'(I1_IMM_W));
            default: ;
        endcase
    end

    always_comb begin
        err_rng_n = err_rng_q;
        if (accept && range_bad_c) err_rng_n = 1'b1;
        else if (halt_clr)         err_rng_n = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_rng_q <= 1'b0;
        else        err_rng_q <= err_rng_n;
    end

    assign err_range = err_rng_q;
`else
    assign err_range = 1'b0;
`endif

    instr_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .wdata      (word_c),
        .pop        (pop),
        .rdata      (out_instr),
        .valid      (out_valid),
        .full_nxt_c (full_nxt),
        .count      (count)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encoding formats, queue
// backpressure, halt handling, illegal/range errors and mid-stream reset.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [1:0]  in_func;
    logic [2:0]  in_rs;
    logic [2:0]  in_rt;
    logic [2:0]  in_rd;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic        halt_clr;
    logic        halted;
    logic [2:0]  count;
    logic        err_illegal;
    logic        err_range;

    int errors = 0;
    int checks = 0;

    instr_encoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_func     (in_func),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .halt_clr    (halt_clr),
        .halted      (halted),
        .count       (count),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] func, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd, input logic [15:0] imm);
        in_op    = op;
        in_func  = func;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; halt_clr = 1'b0;
        in_op = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        #1 rst_n = 1'b0;
        #2;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL rst_out_instr: got %h want 0000", out_instr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
        checks++; if (err_illegal !== 1'b0 || err_range !== 1'b0) begin errors++; $display("FAIL rst_errs: got %b%b want 00", err_illegal, err_range); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_encode();
        logic [4:0]  t_op   [10];
        logic [1:0]  t_func [10];
        logic [2:0]  t_rs   [10];
        logic [2:0]  t_rt   [10];
        logic [2:0]  t_rd   [10];
        logic [15:0] t_imm  [10];
        logic [15:0] t_exp  [10];
        t_op   = '{5'b01000, 5'b01000, 5'b00100, 5'b01100, 5'b00001, 5'b11011, 5'b11100, 5'b11001, 5'b10000, 5'b11000};
        t_func = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
        t_rs   = '{3'd2, 3'd2, 3'd0, 3'd5, 3'd7, 3'd1, 3'd1, 3'd3, 3'd1, 3'd4};
        t_rt   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd2, 3'd2, 3'd7, 3'd0, 3'd0};
        t_rd   = '{3'd2, 3'd3, 3'd0, 3'd0, 3'd7, 3'd4, 3'd4, 3'd6, 3'd7, 3'd0};
        t_imm  = '{16'hFFFF, 16'hFFFF, 16'h0123, 16'hFFF0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h000F, 16'h007F};
        t_exp  = '{16'h425F, 16'h427F, 16'h2123, 16'h65F0, 16'h0800, 16'hD951, 16'hE150, 16'hCB18, 16'h81EF, 16'hC47F};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(t_op[i], t_func[i], t_rs[i], t_rt[i], t_rd[i], t_imm[i]);
            tick();
            checks++; if (out_valid !== 1'b1 || out_instr !== t_exp[i]) begin errors++; $display("FAIL encode_%0d: got v=%b %h want v=1 %h", i, out_valid, out_instr, t_exp[i]); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL encode_count_%0d: got %0d want 1", i, count); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL encode_drain: got v=%b c=%0d want v=0 c=0", out_valid, count); end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        logic [15:0] exp_q [4];
        exp_q = '{16'hD900, 16'hDA00, 16'hDB00, 16'hDC00};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(5'b11011, 2'd0, 3'(i), 3'd0, 3'd0, 16'h0000);
            tick();
            checks++; if (count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin errors++; $display("FAIL full_count_%0d: got %0d", i, count); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        checks++; if (out_instr !== 16'hD800) begin errors++; $display("FAIL full_head: got %h want D800", out_instr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_pop: got c=%0d r=%b want c=3 r=1", count, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b1 || out_instr !== exp_q[k]) begin errors++; $display("FAIL full_order_%0d: got v=%b %h want %h", k, out_valid, out_instr, exp_q[k]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_empty: got v=%b c=%0d r=%b", out_valid, count, in_ready); end
    endtask

    task automatic test_halt();
        out_ready = 1'b0;
        drive(5'b00000, 2'd3, 3'd7, 3'd7, 3'd7, 16'hFFFF);
        tick();
        checks++; if (halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_set: got h=%b r=%b want h=1 r=0", halted, in_ready); end
        checks++; if (out_valid !== 1'b1 || out_instr !== 16'h0000 || count !== 3'd1) begin errors++; $display("FAIL halt_word: got v=%b %h c=%0d", out_valid, out_instr, count); end
        drive(5'b11011, 2'd0, 3'd1, 3'd0, 3'd0, 16'h0000);
        tick();
        tick();
        checks++; if (count !== 3'd1 || halted !== 1'b1) begin errors++; $display("FAIL halt_stall: got c=%0d h=%b want c=1 h=1", count, halted); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL halt_drain: got c=%0d v=%b h=%b r=%b", count, out_valid, halted, in_ready); end
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL halt_clr: got h=%b r=%b want h=0 r=1", halted, in_ready); end
        tick();
        checks++; if (count !== 3'd1 || out_instr !== 16'hD900) begin errors++; $display("FAIL halt_resume: got c=%0d %h want c=1 D900", count, out_instr); end
        drive(5'b00000, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
        halt_clr = 1'b1;
        tick();
        halt_clr = 1'b0;
        in_valid = 1'b0;
        checks++; if (halted !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL halt_clr_race: got h=%b c=%0d want h=1 c=2", halted, count); end
        halt_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        halt_clr = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (halted !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL halt_cleanup: got h=%b c=%0d want h=0 c=0", halted, count); end
    endtask

    task automatic test_illegal();
        logic exp_rng;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        out_ready = 1'b0;
        drive(5'b00010, 2'd1, 3'd1, 3'd1, 3'd1, 16'h1234);
        tick();
        in_valid = 1'b0;
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", err_illegal); end
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL illegal_nowrite: got c=%0d v=%b r=%b", count, out_valid, in_ready); end
        drive(5'b10101, 2'd0, 3'd1, 3'd0, 3'd2, 16'h0020);
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd1 || out_instr !== 16'hA940) begin errors++; $display("FAIL range_word: got c=%0d %h want c=1 A940", count, out_instr); end
        checks++; if (err_range !== exp_rng) begin errors++; $display("FAIL range_flag: got %b want %b", err_range, exp_rng); end
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", err_illegal); end
        halt_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        halt_clr = 1'b0;
        out_ready = 1'b0;
        checks++; if (err_illegal !== 1'b0 || err_range !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL err_clear: got i=%b r=%b c=%0d", err_illegal, err_range, count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(5'b11011, 2'd0, 3'(i), 3'd0, 3'd0, 16'h0000);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_queued: got %0d want 3", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 16'h0000) begin errors++; $display("FAIL mid_reset: got c=%0d v=%b %h", count, out_valid, out_instr); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release: got r=%b c=%0d v=%b", in_ready, count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_full();
        test_halt();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
